// File: rtl/rv_pkg.sv
// Shared definitions for the rv_alu_arb slice: datapath widths, ALU opcode
// encodings and the arbiter/sequencer state encoding.
package rv_pkg;

   localparam int XLEN = 32;
   localparam int OPW  = 4;

   localparam logic [OPW-1:0] ALU_ADD = 4'd0;
   localparam logic [OPW-1:0] ALU_SUB = 4'd1;
   localparam logic [OPW-1:0] ALU_AND = 4'd2;
   localparam logic [OPW-1:0] ALU_OR  = 4'd3;
   localparam logic [OPW-1:0] ALU_XOR = 4'd4;
   localparam logic [OPW-1:0] ALU_SLL = 4'd5;
   localparam logic [OPW-1:0] ALU_SRL = 4'd6;
   localparam logic [OPW-1:0] ALU_SLT = 4'd7;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rv_alu_arb_if.sv
// Bundle of the request, response and ALU-side signals of rv_alu_arb.
// The slave modport is the arbiter's view; master is the view of the
// requesters and the ALU surrounding it.
interface rv_alu_arb_if #(
   parameter int XLEN = rv_pkg::XLEN,
   parameter int OPW  = rv_pkg::OPW
);
   logic            req0_valid;
   logic            req0_ready;
   logic [OPW-1:0]  req0_op;
   logic [XLEN-1:0] req0_a;
   logic [XLEN-1:0] req0_b;

   logic            req1_valid;
   logic            req1_ready;
   logic [OPW-1:0]  req1_op;
   logic [XLEN-1:0] req1_a;
   logic [XLEN-1:0] req1_b;

   logic            rsp0_valid;
   logic            rsp0_ready;
   logic            rsp1_valid;
   logic            rsp1_ready;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_err;

   logic            alu_start;
   logic [OPW-1:0]  alu_op;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic            alu_done;
   logic [XLEN-1:0] alu_result;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready,
      input  alu_done, alu_result,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
      output alu_start, alu_op, alu_a, alu_b
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp0_ready, rsp1_ready,
      output alu_done, alu_result,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
      input  alu_start, alu_op, alu_a, alu_b
   );

endinterface

// File: rtl/rv_arb2.sv
// Two-input grant logic for rv_alu_arb.
// Build option RV_ALU_ARB_RR_EN: when defined, simultaneous requests are
// granted round-robin using the 'last' pointer (the port that did not win
// last time wins); when undefined, port 0 always has priority and there is
// no 'last' input at all.
module rv_arb2 (
   input  logic [1:0] valid,
`ifdef RV_ALU_ARB_RR_EN
   input  logic       last,
`endif
   output logic [1:0] grant
);

   // One-hot grant from the current valids; all zero when nobody asks.
   always_comb begin
      grant = 2'b00;
`ifdef RV_ALU_ARB_RR_EN
      if (valid == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end else begin
         grant = valid;
      end
`else
      grant[0] = valid[0];
      grant[1] = valid[1] & ~valid[0];
`endif
   end

endmodule

// File: rtl/rv_alu_arb.sv
// Sequencer/arbiter that shares one rv_alu between the execute stage
// (port 0) and the address/branch-compare unit (port 1). A request is
// accepted in IDLE, issued to the ALU with a one-cycle start pulse, the
// done strobe is awaited under a watchdog, and the registered result is
// handed back to the owning port over valid/ready.
// Build option RV_ALU_ARB_RR_EN selects round-robin arbitration (with the
// 'last' pointer register); undefined gives fixed priority to port 0.
module rv_alu_arb #(
   parameter int XLEN    = rv_pkg::XLEN,
   parameter int OPW     = rv_pkg::OPW,
   parameter int TIMEOUT = 15
) (
   input logic         clk,
   input logic         rst,
   rv_alu_arb_if.slave bus
);
   import rv_pkg::*;

   // The watchdog counter is 8 bits wide since TIMEOUT never exceeds 255.
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   arb_state_t      state;
   logic            owner;
   logic [7:0]      wdog_cnt;
   logic [7:0]      wdog_next;
   logic [1:0]      req_valid;
   logic [1:0]      grant;
   logic            hs0;
   logic            hs1;
   logic            start_q;
   logic            rsp0_q;
   logic            rsp1_q;
   logic            err_q;
   logic [OPW-1:0]  op_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] data_q;
`ifdef RV_ALU_ARB_RR_EN
   logic            last;
`endif

   assign req_valid = {bus.req1_valid, bus.req0_valid};

   rv_arb2 u_arb2 (
      .valid (req_valid),
`ifdef RV_ALU_ARB_RR_EN
      .last  (last),
`endif
      .grant (grant)
   );

   // Only the grant winner sees ready, and only while idle and out of reset.
   assign bus.req0_ready = (state == ARB_IDLE) && !rst && grant[0];
   assign bus.req1_ready = (state == ARB_IDLE) && !rst && grant[1];
   assign hs0            = bus.req0_ready && bus.req0_valid;
   assign hs1            = bus.req1_ready && bus.req1_valid;
   assign wdog_next      = wdog_cnt + 8'd1;

   assign bus.alu_start  = start_q;
   assign bus.alu_op     = op_q;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.rsp0_valid = rsp0_q;
   assign bus.rsp1_valid = rsp1_q;
   assign bus.rsp_data   = data_q;
   assign bus.rsp_err    = err_q;

   // Sequencer FSM: accept, issue, wait for done or watchdog, respond.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         owner    <= 1'b0;
         wdog_cnt <= 8'd0;
         start_q  <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         rsp0_q   <= 1'b0;
         rsp1_q   <= 1'b0;
`ifdef RV_ALU_ARB_RR_EN
         last     <= 1'b1;
`endif
      end else begin
         start_q <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (hs0 || hs1) begin
                  op_q    <= hs1 ? bus.req1_op : bus.req0_op;
                  a_q     <= hs1 ? bus.req1_a  : bus.req0_a;
                  b_q     <= hs1 ? bus.req1_b  : bus.req0_b;
                  owner   <= hs1;
                  start_q <= 1'b1;
                  state   <= ARB_ISSUE;
`ifdef RV_ALU_ARB_RR_EN
                  last    <= hs1;
`endif
               end
            end
            ARB_ISSUE: begin
               wdog_cnt <= 8'd0;
               if (bus.alu_done) begin
                  data_q <= bus.alu_result;
                  err_q  <= 1'b0;
                  rsp0_q <= !owner;
                  rsp1_q <= owner;
                  state  <= ARB_RESP;
               end else begin
                  state  <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               wdog_cnt <= wdog_next;
               if (bus.alu_done) begin
                  data_q <= bus.alu_result;
                  err_q  <= 1'b0;
                  rsp0_q <= !owner;
                  rsp1_q <= owner;
                  state  <= ARB_RESP;
               end else if (wdog_next == TIMEOUT_CNT) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
                  rsp0_q <= !owner;
                  rsp1_q <= owner;
                  state  <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                  rsp0_q <= 1'b0;
                  rsp1_q <= 1'b0;
                  state  <= ARB_IDLE;
               end
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_alu_arb.sv
// Directed testbench for rv_alu_arb. A small behavioural ALU answers each
// start pulse after a programmable latency (alu_lat, -1 = never answers).
// Grant-order expectations follow RV_ALU_ARB_RR_EN.
module tb_rv_alu_arb;
   import rv_pkg::*;

   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   alu_lat = 0;

   always #5 clk = ~clk;

   rv_alu_arb_if #(.XLEN(32), .OPW(4)) bus ();

   rv_alu_arb #(.XLEN(32), .OPW(4), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] alu_func(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   // Behavioural ALU: done arrives alu_lat cycles after the start pulse.
   initial begin : alu_model
      int          cnt;
      logic        pend;
      logic [31:0] res;
      cnt = 0;
      pend = 1'b0;
      res = '0;
      bus.alu_done = 1'b0;
      bus.alu_result = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.alu_done = 1'b0;
         bus.alu_result = '0;
         if (bus.alu_start) begin
            cnt = alu_lat;
            pend = (alu_lat >= 0);
            res = alu_func(bus.alu_op, bus.alu_a, bus.alu_b);
         end
         if (pend) begin
            if (cnt == 0) begin
               bus.alu_done = 1'b1;
               bus.alu_result = res;
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise a request, wait (bounded) for its ready, handshake, drop valid.
   task automatic send(input int port, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       output int waited);
      logic rdy;
      if (port == 0) begin
         bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end
      #1;
      waited = 0;
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      while (!rdy && waited < 20) begin
         tick();
         waited++;
         rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      end
      if (!rdy) waited = -1;
      tick();
      if (port == 0) bus.req0_valid = 1'b0;
      else           bus.req1_valid = 1'b0;
   endtask

   // Count cycles from the accept edge until a response valid appears.
   task automatic wait_rsp(output int n);
      n = 1;
      while (!(bus.rsp0_valid || bus.rsp1_valid) && n < 40) begin
         tick();
         n++;
      end
      if (!(bus.rsp0_valid || bus.rsp1_valid)) n = -1;
   endtask

   task automatic test_reset();
      bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp0_ready = 0; bus.rsp1_ready = 0;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.alu_start, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err,
           bus.req0_ready, bus.req1_ready} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 000000", {bus.alu_start,
                  bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.req0_ready, bus.req1_ready});
      end
      checks++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_data} !== 100'b0) begin
         errors++;
         $display("[TB] FAIL reset_data: got op=%0h a=%0h b=%0h data=%0h expected all 0",
                  bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int w;
      int n;
      alu_lat = 0;
      bus.rsp0_ready = 1'b1;
      send(0, ALU_ADD, 32'd5, 32'd7, w);
      checks++;
      if (w !== 0) begin errors++; $display("[TB] FAIL single_grant: waited %0d expected 0", w); end
      checks++;
      if ({bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b1, ALU_ADD, 32'd5, 32'd7}) begin
         errors++;
         $display("[TB] FAIL single_issue: got start=%b op=%0h a=%0d b=%0d expected 1/0/5/7",
                  bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      wait_rsp(n);
      checks++;
      if (n !== 2) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 2", n); end
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.alu_start} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL single_flags: got v0v1/err/start=%b expected 1000",
                  {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.alu_start});
      end
      checks++;
      if (bus.rsp_data !== 32'd12) begin
         errors++; $display("[TB] FAIL single_data: got %0d expected 12", bus.rsp_data);
      end
      tick();
      checks++;
      if (bus.rsp0_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL single_release: rsp0_valid got %b expected 0", bus.rsp0_valid);
      end
   endtask

   task automatic test_latency();
      int w;
      int n;
      alu_lat = 4;
      bus.rsp1_ready = 1'b1;
      send(1, ALU_SUB, 32'd10, 32'd3, w);
      checks++;
      if (w !== 0) begin errors++; $display("[TB] FAIL lat_grant: waited %0d expected 0", w); end
      wait_rsp(n);
      checks++;
      if (n !== 6) begin errors++; $display("[TB] FAIL lat_cycles: got %0d expected 6", n); end
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL lat_flags: got v0v1/err=%b expected 010",
                  {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err});
      end
      checks++;
      if (bus.rsp_data !== 32'd7) begin
         errors++; $display("[TB] FAIL lat_data: got %0d expected 7", bus.rsp_data);
      end
      tick();
   endtask

   task automatic test_contention();
      int exp_g [4];
      int g;
      int n;
      int m;
`ifdef RV_ALU_ARB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      alu_lat = 0;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_op = ALU_ADD; bus.req0_a = 32'd1;    bus.req0_b = 32'd2;
      bus.req1_valid = 1'b1; bus.req1_op = ALU_AND; bus.req1_a = 32'hF0;   bus.req1_b = 32'h3C;
      #1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(bus.req0_ready || bus.req1_ready) && n < 10) begin
            tick();
            n++;
         end
         if (bus.req0_ready && !bus.req1_ready)      g = 0;
         else if (bus.req1_ready && !bus.req0_ready) g = 1;
         else                                        g = -1;
         checks++;
         if (g !== exp_g[i]) begin
            errors++; $display("[TB] FAIL contention_grant%0d: got %0d expected %0d", i, g, exp_g[i]);
         end
         tick();
         wait_rsp(m);
         checks++;
         if ((m !== 2) || (bus.rsp_data !== ((exp_g[i] == 1) ? 32'h30 : 32'd3))) begin
            errors++;
            $display("[TB] FAIL contention_rsp%0d: got cycles=%0d data=%0h expected 2/%0h", i, m,
                     bus.rsp_data, (exp_g[i] == 1) ? 32'h30 : 32'd3);
         end
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic test_watchdog();
      int w;
      int n;
      alu_lat = -1;
      bus.rsp0_ready = 1'b0;
      send(0, ALU_XOR, 32'hAA, 32'h55, w);
      wait_rsp(n);
      checks++;
      if (n !== TIMEOUT + 2) begin
         errors++; $display("[TB] FAIL wdog_cycles: got %0d expected %0d", n, TIMEOUT + 2);
      end
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err} !== 3'b101 || bus.rsp_data !== 32'd0) begin
         errors++;
         $display("[TB] FAIL wdog_rsp: got v0v1/err=%b data=%0h expected 101/0",
                  {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err}, bus.rsp_data);
      end
      bus.rsp0_ready = 1'b1;
      tick();
      checks++;
      if (bus.rsp0_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL wdog_release: rsp0_valid got %b expected 0", bus.rsp0_valid);
      end
      alu_lat = 0;
      bus.rsp1_ready = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_op = ALU_ADD; bus.req1_a = 32'd2; bus.req1_b = 32'd3;
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL wdog_idle: req1_ready got %b expected 1", bus.req1_ready);
      end
      tick();
      bus.req1_valid = 1'b0;
      wait_rsp(n);
      checks++;
      if (bus.rsp_data !== 32'd5 || bus.rsp_err !== 1'b0 || n !== 2) begin
         errors++;
         $display("[TB] FAIL wdog_next: got data=%0d err=%b cycles=%0d expected 5/0/2",
                  bus.rsp_data, bus.rsp_err, n);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int w;
      int n;
      alu_lat = 2;
      bus.rsp0_ready = 1'b0;
      send(0, ALU_OR, 32'h0F, 32'hF0, w);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_op = ALU_SUB; bus.req1_a = 32'd9; bus.req1_b = 32'd1;
      wait_rsp(n);
      checks++;
      if (n !== 4) begin errors++; $display("[TB] FAIL bp_cycles: got %0d expected 4", n); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.rsp0_valid, bus.rsp_err} !== 2'b10 || bus.rsp_data !== 32'hFF) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d: got v0/err=%b data=%0h expected 10/ff", i,
                     {bus.rsp0_valid, bus.rsp_err}, bus.rsp_data);
         end
         checks++;
         if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bp_ready%0d: got %b expected 00", i, {bus.req0_ready, bus.req1_ready});
         end
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b1;
      tick();
      checks++;
      if (bus.rsp0_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL bp_release: rsp0_valid got %b expected 0", bus.rsp0_valid);
      end
   endtask

   task automatic test_reset_mid_wait();
      int w;
      int n;
      alu_lat = 6;
      bus.rsp1_ready = 1'b1;
      send(1, ALU_ADD, 32'd100, 32'd23, w);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.alu_start, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err} !== 4'b0 ||
          {bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_data} !== 100'b0) begin
         errors++;
         $display("[TB] FAIL rstwait_outputs: got start=%b v=%b%b err=%b op=%0h a=%0h b=%0h data=%0h expected all 0",
                  bus.alu_start, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err,
                  bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_data);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rstwait_norsp%0d: got %b expected 00", i, {bus.rsp0_valid, bus.rsp1_valid});
         end
         tick();
      end
      alu_lat = 1;
      bus.rsp0_ready = 1'b1;
      send(0, ALU_SUB, 32'd50, 32'd8, w);
      checks++;
      if (w !== 0) begin errors++; $display("[TB] FAIL rstwait_grant: waited %0d expected 0", w); end
      wait_rsp(n);
      checks++;
      if (n !== 3 || bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 32'd42 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstwait_next: got cycles=%0d v0=%b data=%0d err=%b expected 3/1/42/0",
                  n, bus.rsp0_valid, bus.rsp_data, bus.rsp_err);
      end
      tick();
   endtask

   initial begin
      bus.req0_valid = 0; bus.req1_valid = 0;
      bus.rsp0_ready = 0; bus.rsp1_ready = 0;
      $display("[TB] starting rv_alu_arb directed tests");
      test_reset();
      test_single();
      test_latency();
      test_contention();
      test_watchdog();
      test_backpressure();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_alu_arb.md
# rv_alu_arb

Sequencer and arbiter sharing the single `rv_alu` execution unit between two requesters: the execute stage (port 0) and the address/branch-compare unit (port 1). It accepts operation requests over valid/ready, grants one at a time, and drives the ALU operands with a one-cycle start pulse. It waits for the ALU's done strobe, guarded by a watchdog, and returns the registered result to the granted requester over valid/ready.

## Interface
- `XLEN`, 32, operand/result width
- `OPW`, 4, ALU opcode width
- `TIMEOUT`, 15, max cycles from `alu_start` to `alu_done` before abort; legal range 1..255
- One clock `clk`. Reset is synchronous and active-high: `rst`.
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `req0_valid`/`req1_valid` in 1: request pending
- `req0_ready`/`req1_ready` out 1: request accepted this cycle when valid & ready
- `req0_op`/`req1_op` in OPW: ALU opcode
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in XLEN: operands
- `rsp0_valid`/`rsp1_valid` out 1: result available
- `rsp0_ready`/`rsp1_ready` in 1: requester takes result
- `rsp_data` out XLEN: result, shared by both ports
- `rsp_err` out 1: result is a watchdog abort
- `alu_start` out 1: one-cycle start pulse to ALU
- `alu_op` out OPW, `alu_a`/`alu_b` out XLEN: registered ALU inputs
- `alu_done` in 1: ALU result valid
- `alu_result` in XLEN: ALU output

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `reqN_ready` = 1 only for the current grant winner, and only in IDLE.
  - On handshake: latch op/a/b into `alu_*` registers, latch `owner`, go to ISSUE.
- **ISSUE**
  - `alu_start` = 1 for exactly this cycle; watchdog counter loads 0.
  - If `alu_done` is also high (combinational ALU): capture result, go to RESP.
  - Otherwise go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - On `alu_done`: capture `alu_result` into `rsp_data`, `rsp_err`=0, go to RESP.
  - When counter == TIMEOUT with no done: `rsp_data`=0, `rsp_err`=1, go to RESP.
- **RESP**
  - `rsp<owner>_valid` = 1; `rsp_data`/`rsp_err` held stable until `rsp<owner>_ready`, then go to IDLE.
  - The non-owner valid stays 0.
- `alu_done` outside ISSUE/WAIT is ignored.
- Operands and opcode pass through unmodified; no width conversion.
- Reset values: state IDLE, every output 0, grant pointer `last`=1 (port 0 wins first), counter 0, `owner` 0.
- Reset asserted mid-operation returns to IDLE next edge; the in-flight result is discarded and no response is issued.

## Timing
- Request accepted at edge N, `alu_start` high cycle N+1.
- With done at cycle N+1+k (k ≥ 0): `rspN_valid` rises at cycle N+2+k.
- Minimum turnaround, with a combinational ALU and immediate `rsp_ready`: 3 cycles per op (IDLE, ISSUE, RESP).
- A watchdog abort produces `rsp_valid` at cycle N+2+TIMEOUT.
- Arbitration is decided combinationally in IDLE from the current valids and the `last` pointer; `last` updates on handshake.
- Simultaneous valids are resolved in the same cycle; the loser stays un-ready until the next IDLE.

## Configuration
- `RV_ALU_ARB_RR_EN` defined: round-robin arbitration; on simultaneous valids, grant the port ≠ `last`.
- `RV_ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins; `last` register is removed.

## Structure
- Shared package `rv_pkg` holds:
  - `XLEN`
  - ALU opcode localparams (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, …)
  - state encoding `ARB_IDLE`/`ARB_ISSUE`/`ARB_WAIT`/`ARB_RESP`
- One sub-module `rv_arb2`: the two-input grant logic (round-robin or fixed priority under the macro), with inputs valids/`last` and output grant.

## Test plan
- Reset then single request: `req0` ADD a=5 b=7, ALU done with start → `alu_start` 1 cycle after accept, `rsp0_valid` next cycle, `rsp_data`=12, `rsp_err`=0.
- Variable latency: `req1` SUB a=10 b=3, done 4 cycles after start → `rsp1_valid` at accept+6, data=7; `rsp0_valid` stays 0.
- Contention: both valid every cycle, macro defined → grants alternate 0,1,0,1 over 4 ops. Macro undefined → 4 consecutive grants to port 0.
- Watchdog: TIMEOUT=15, done never asserted → `rsp_valid` at accept+17, data=0, `rsp_err`=1; FSM returns to IDLE.
- Backpressure: `rsp0_ready` held 0 for 5 cycles → `rsp_data` stable, `req0_ready` and `req1_ready` stay 0 throughout.
- Reset mid-WAIT: `rst` pulse during WAIT, then a late `alu_done` → no `rsp_valid`, all outputs 0, next request served normally.
